// File: rtl/imem_arbiter_pkg.sv
// Shared types for the IMEM arbiter: phase encoding, response owner, starvation defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imem_arbiter_pkg;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_FE   = 2'd1,
        OWN_LD   = 2'd2
    } rsp_owner_t;

    localparam int STARVE_LIMIT_DEF = 4;
    localparam int STARVE_CNT_BITS  = 4;

endpackage

// File: rtl/imem_arb_starve_ctr.sv
// Saturating loader wait counter; flags starvation once LIMIT waits have accumulated.
// Latency: starved reflects the registered count (one cycle after the counted wait).
// Backpressure: none; clr has priority over inc.
module imem_arb_starve_ctr
    import imem_arbiter_pkg::*;
#(
    parameter int LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic starved
);

    localparam logic [STARVE_CNT_BITS-1:0] LIM = STARVE_CNT_BITS'(LIMIT);

    logic [STARVE_CNT_BITS-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q < LIM)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign starved = (cnt_q >= LIM);

endmodule

// File: rtl/imem_arbiter.sv
// Single-port IMEM arbiter: loader-only BOOT phase, then fetch-priority RUN with bounded loader starvation.
// Latency: grant/ready combinational in the request cycle; read response exactly one cycle after grant.
// Backpressure: loser's ready held low; flush cancels fetch responses. IMEM_ARB_PERF_EN adds perf counters.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int ADDR_BITS    = 14,
    parameter int DATA_BITS    = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fe_req_valid,
    input  logic [ADDR_BITS-1:0] fe_req_addr,
    output logic                 fe_req_ready,
    output logic                 fe_rsp_valid,
    output logic [DATA_BITS-1:0] fe_rsp_data,
    output logic                 fe_hold,
    input  logic                 flush,
    input  logic                 ld_req_valid,
    input  logic                 ld_req_we,
    input  logic [ADDR_BITS-1:0] ld_req_addr,
    input  logic [DATA_BITS-1:0] ld_req_wdata,
    output logic                 ld_req_ready,
    output logic                 ld_rsp_valid,
    output logic [DATA_BITS-1:0] ld_rsp_data,
    input  logic                 ld_boot_done,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_BITS-3:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_wdata,
    input  logic [DATA_BITS-1:0] mem_rdata
`ifdef IMEM_ARB_PERF_EN
    ,
    output logic [31:0]          perf_fe_grants,
    output logic [31:0]          perf_ld_grants,
    output logic [31:0]          perf_conflicts
`endif
);

    arb_state_t state_q, state_d;
    rsp_owner_t owner_q, owner_d;
    logic       fe_grant, ld_grant;
    logic       starved;
    logic       unused_addr_lsbs;

    assign unused_addr_lsbs = ^{fe_req_addr[1:0], ld_req_addr[1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_BOOT;
            owner_q <= OWN_NONE;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Grants are forced low while reset is asserted so the IMEM port is quiet during reset.
    always_comb begin
        state_d  = state_q;
        fe_grant = 1'b0;
        ld_grant = 1'b0;
        case (state_q)
            ST_BOOT: begin
                ld_grant = ld_req_valid;
                if (ld_boot_done) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (fe_req_valid && !(starved && ld_req_valid)) begin
                    fe_grant = 1'b1;
                end else begin
                    ld_grant = ld_req_valid;
                end
            end
            default: state_d = ST_BOOT;
        endcase
        if (!reset) begin
            fe_grant = 1'b0;
            ld_grant = 1'b0;
        end
    end

    always_comb begin
        owner_d = OWN_NONE;
        if (fe_grant && !flush) begin
            owner_d = OWN_FE;
        end else if (ld_grant && !ld_req_we) begin
            owner_d = OWN_LD;
        end
    end

    imem_arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk     (clk),
        .reset   (reset),
        .clr     (ld_grant || (state_q == ST_BOOT)),
        .inc     (ld_req_valid && !ld_grant),
        .starved (starved)
    );

    assign fe_req_ready = fe_grant;
    assign ld_req_ready = ld_grant;
    assign fe_hold      = (state_q == ST_BOOT);

    assign mem_en    = fe_grant || ld_grant;
    assign mem_we    = ld_grant && ld_req_we;
    assign mem_addr  = fe_grant ? fe_req_addr[ADDR_BITS-1:2] :
                       ld_grant ? ld_req_addr[ADDR_BITS-1:2] : '0;
    assign mem_wdata = mem_we ? ld_req_wdata : '0;

    // A flush in the response cycle still kills the fetch response already in flight.
    assign fe_rsp_valid = (owner_q == OWN_FE) && !flush;
    assign fe_rsp_data  = fe_rsp_valid ? mem_rdata : '0;
    assign ld_rsp_valid = (owner_q == OWN_LD);
    assign ld_rsp_data  = ld_rsp_valid ? mem_rdata : '0;

`ifdef IMEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fe_grants <= '0;
            perf_ld_grants <= '0;
            perf_conflicts <= '0;
        end else if (state_q == ST_RUN) begin
            if (fe_grant) begin
                perf_fe_grants <= perf_fe_grants + 32'd1;
            end
            if (ld_grant) begin
                perf_ld_grants <= perf_ld_grants + 32'd1;
            end
            if (fe_req_valid && ld_req_valid) begin
                perf_conflicts <= perf_conflicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Arbitrates the single-port instruction memory between the fetch stage (read-only instruction fetch) and the program loader/debug port (read/write). It sequences a boot phase in which only the loader may access IMEM while fetch is held, then enters a run phase with fetch priority and bounded loader starvation. It sits between FE_STAGE's fetch address/instruction path and the IMEM array, and takes the AGEX branch-mispredict flush to cancel in-flight fetch responses.

## Interface
- `ADDR_BITS`, default 14: IMEM byte-address width; word index is `addr[ADDR_BITS-1:2]`.
- `DATA_BITS`, default 32: instruction/data word width.
- `STARVE_LIMIT`, default 4: loader wait cycles before it overrides fetch priority; range 1..15.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `fe_req_valid` in 1: fetch request.
- `fe_req_addr` in ADDR_BITS: fetch byte address (PC).
- `fe_req_ready` out 1: fetch request accepted this cycle.
- `fe_rsp_valid` out 1: fetch instruction valid.
- `fe_rsp_data` out DATA_BITS: fetched instruction.
- `fe_hold` out 1: FE must stall (boot phase).
- `flush` in 1: AGEX mispredict; cancels outstanding fetch response.
- `ld_req_valid` in 1, `ld_req_we` in 1, `ld_req_addr` in ADDR_BITS, `ld_req_wdata` in DATA_BITS: loader request.
- `ld_req_ready` out 1: loader request accepted.
- `ld_rsp_valid` out 1, `ld_rsp_data` out DATA_BITS: loader read response (none for writes).
- `ld_boot_done` in 1: single-cycle pulse ending boot phase.
- `mem_en` out 1, `mem_we` out 1, `mem_addr` out ADDR_BITS-2, `mem_wdata` out DATA_BITS: IMEM port.
- `mem_rdata` in DATA_BITS: IMEM read data, valid one cycle after `mem_en && !mem_we`.

## Operation
- States: BOOT, RUN. Reset enters BOOT.
- BOOT: `fe_hold`=1, `fe_req_ready`=0; loader granted whenever `ld_req_valid`. `ld_boot_done`=1 -> RUN next cycle; a loader request in the same cycle is still granted.
- RUN: `fe_hold`=0. Grant fetch if `fe_req_valid` unless `starve_cnt >= STARVE_LIMIT` and `ld_req_valid`, then grant loader. Loader granted when fetch not requesting.
- Exactly one grant per cycle; `ready` of the granted requester is 1, other 0. `mem_en` = any grant; `mem_we` = `ld_req_we` on loader grant, else 0. `mem_addr` = granted `addr[ADDR_BITS-1:2]`.
- `starve_cnt` (4 bits): +1 per cycle with `ld_req_valid` not granted, saturates at STARVE_LIMIT; cleared on loader grant and in BOOT.
- Response owner register records grant (FE, LD-read, none). Next cycle the owner's `rsp_valid`=1 and `rsp_data`=`mem_rdata`; LD writes produce no response.
- Flush: `flush`=1 in the grant cycle or the response cycle suppresses that `fe_rsp_valid` to 0. A fetch request granted in the same cycle as `flush` is cancelled. Flush never affects loader traffic.
- `ld_boot_done` in RUN is ignored; no return to BOOT except reset.
- Reset mid-operation: outstanding response is dropped; all outputs reset: `fe_hold`=1, all ready/valid/mem_en/mem_we 0, data/addr outputs 0, `starve_cnt`=0.

## Timing
- Grant combinational from valids and registered state; ready same cycle as request.
- Read latency: response exactly 1 cycle after grant; back-to-back grants yield back-to-back responses.
- State, `starve_cnt`, owner register update on rising `clk`; reset asynchronous assert, synchronous-to-clk deassert expected at top level.
- `rsp_data` held only while `rsp_valid`=1; 0 otherwise.

## Configuration
- `IMEM_ARB_PERF_EN`: defined -> adds 32-bit outputs `perf_fe_grants`, `perf_ld_grants`, `perf_conflicts` (both valid same cycle), wrapping counters, reset to 0, counting in RUN only. Undefined -> ports and counters absent; arbitration identical.

## Structure
- Shared package: state encoding (BOOT, RUN), response-owner encoding (NONE, FE, LD), STARVE_LIMIT default constant.
- One sub-module: `imem_arb_starve_ctr` (saturating wait counter with clear/enable, emits `starved`).

## Test plan
- Reset, `ld_req_valid`=1, we=1, addr=0x0, wdata=0x00000013 -> `ld_req_ready`=1, `mem_we`=1, `fe_hold`=1, `fe_req_ready`=0.
- BOOT, `ld_boot_done` pulse, then `fe_req_valid`, addr=0x0 -> next cycle `fe_rsp_valid`=1, data=0x00000013.
- RUN, both valid continuously, STARVE_LIMIT=4 -> FE granted 4 cycles, loader cycle 5, pattern repeats.
- FE grant at cycle N, `flush`=1 at N+1 -> `fe_rsp_valid`=0 at N+1; next fetch responds normally.
- Loader read addr=0x4 in RUN with FE idle -> `ld_rsp_valid`=1 one cycle later; `fe_rsp_valid` stays 0.
- `reset` low during outstanding FE read -> `fe_rsp_valid`=0, state BOOT, `fe_hold`=1 immediately.
